tile_block_reader: RTL and testbench

- Read-side counterpart of the MatMul result-block writer.
- Fetches one 8x8 tile of `DATA_WIDTH elements from the shared scratch memory: 8 row reads at base_addr + r*stride, each row one `BANDWIDTH-wide word.
- Assembles the rows into a tile register and signals completion to the 8x8 multiply datapath.
- One instance each feeds operand A and operand B of the block multiplier.

---
 rtl/tile_pkg.sv | 33 +++
 rtl/tile_block_reader_if.sv | 20 ++
 rtl/read_tag_pipe.sv | 25 ++
 rtl/tile_block_reader.sv | 80 ++++++++
 tb/tb_tile_block_reader.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/tile_pkg.sv
// Shared widths and types for the tile block reader. Widths default here unless
// DATA_WIDTH / BANDWIDTH / ADDR_WIDTH / DIM_WIDTH are defined on the command line.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DIM_WIDTH
`define DIM_WIDTH 8
`endif

package tile_pkg;
    localparam int TILE_DIM = 8;
    localparam int DATA_W   = `DATA_WIDTH;
    localparam int BAND_W   = `BANDWIDTH;
    localparam int ADDR_W   = `ADDR_WIDTH;
    localparam int DIM_W    = `DIM_WIDTH;

    typedef logic [BAND_W-1:0][DATA_W-1:0] tile_row_t;
    typedef tile_row_t [7:0] tile_t;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    // Row tag travelling alongside an outstanding read
    typedef struct packed {
        logic       valid;
        logic [2:0] row;
    } tag_t;
endpackage

// File: rtl/tile_block_reader_if.sv
// Command and memory-read bus of the tile block reader.
// master = the reader, slave = the controller/memory side.
interface tile_block_reader_if;
    import tile_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [DIM_W-1:0]    stride;
    logic                busy;
    logic                done;
    tile_t               tile;
    logic                read;
    logic [ADDR_W-1:0]   addr;
    tile_row_t           readdata;

    modport master (input start, base_addr, stride, readdata,
                    output busy, done, tile, read, addr);
    modport slave  (output start, base_addr, stride, readdata,
                    input busy, done, tile, read, addr);
endinterface

// File: rtl/read_tag_pipe.sv
// READ_LATENCY-deep delay line of {valid,row} tags; its output marks the cycle
// in which the matching readdata is on the bus.
module read_tag_pipe
    import tile_pkg::*;
#(
    parameter int READ_LATENCY = 2
) (
    input  logic clock,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t pipe [READ_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[READ_LATENCY-1];
endmodule

// File: rtl/tile_block_reader.sv
// Fetches one 8x8 tile as 8 strided row reads and assembles it into a register.
// Define TILE_TRANSPOSE_EN to store returned row r into column r instead.
module tile_block_reader
    import tile_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int TILE_DIM     = 8
) (
    input  logic                clock,
    input  logic                reset,
    tile_block_reader_if.master bus
);
    state_t            state, state_n;
    logic [2:0]        row_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DIM_W-1:0]  stride_q;
    logic              done_q;
    tile_t             tile_q;
    tag_t              tag_in, tag_out;
    logic              last_capture;

    assign tag_in       = {state == ISSUE, row_cnt};
    assign last_capture = tag_out.valid && (tag_out.row == 3'(TILE_DIM - 1));

    read_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tags (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = ISSUE;
            ISSUE:   if (row_cnt == 3'(TILE_DIM - 1)) state_n = DRAIN;
            DRAIN:   if (last_capture) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address accumulator: one stride step per issued row
    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt  <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            done_q   <= 1'b0;
            tile_q   <= '0;
        end else begin
            done_q <= (state == DRAIN) && last_capture;
            if (state == IDLE && bus.start) begin
                addr_q   <= bus.base_addr;
                stride_q <= bus.stride;
                row_cnt  <= '0;
            end else if (state == ISSUE) begin
                addr_q  <= addr_q + ADDR_W'(stride_q);
                row_cnt <= row_cnt + 3'd1;
            end
            if (tag_out.valid) begin
`ifdef TILE_TRANSPOSE_EN
                for (int c = 0; c < TILE_DIM; c++) tile_q[c][tag_out.row] <= bus.readdata[c];
`else
                tile_q[tag_out.row] <= bus.readdata;
`endif
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.read = (state == ISSUE);
    assign bus.addr = addr_q;
    assign bus.done = done_q;
    assign bus.tile = tile_q;
endmodule

// File: tb/tb_tile_block_reader.sv
// Randomized bench for tile_block_reader: a latency-accurate memory model and
// a reference that derives addresses/tile contents arithmetically per fetch.
module tb_tile_block_reader;
    import tile_pkg::*;

    parameter int LAT = 2;

    logic clock = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    tile_block_reader_if bif ();

    tile_block_reader #(.READ_LATENCY(LAT), .TILE_DIM(TILE_DIM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input int c);
        return DATA_W'(32'(a) * 16 + c);
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory: data for a request seen in cycle k is driven during cycle k+LAT
    initial begin
        logic [ADDR_W:0] req_q [$];
        logic [ADDR_W:0] rq;
        bif.readdata = '0;
        forever begin
            @(posedge clock);
            #1;
            req_q.push_back({bif.read, bif.addr});
            if (req_q.size() > LAT) begin
                rq = req_q.pop_front();
                for (int c = 0; c < BAND_W; c++)
                    bif.readdata[c] = rq[ADDR_W] ? pat(rq[ADDR_W-1:0], c) : DATA_W'($urandom);
            end
        end
    end

    task automatic chk_tile(input string tag, input logic [ADDR_W-1:0] ea [8], input bit zero);
        tile_row_t exp;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < BAND_W; j++) begin
`ifdef TILE_TRANSPOSE_EN
                exp[j] = zero ? '0 : pat(ea[j], i);
`else
                exp[j] = zero ? '0 : pat(ea[i], j);
`endif
            end
            chk($sformatf("%s_row%0d", tag, i), 128'(bif.tile[i]), 128'(exp));
        end
    endtask

    // Starts a fetch in the current cycle and returns in its done cycle.
    // mode 1: stray start in cycle 5; mode 2: start held high while busy.
    task automatic fetch(input logic [ADDR_W-1:0] b, input logic [DIM_W-1:0] s, input int mode);
        logic [ADDR_W-1:0] ea [8];
        for (int r = 0; r < 8; r++) ea[r] = ADDR_W'(32'(b) + r * 32'(s));
        bif.start = 1'b1; bif.base_addr = b; bif.stride = s;
        tick();
        bif.start     = (mode == 2);
        bif.base_addr = (mode == 2) ? (b ^ ADDR_W'(12'h5A5)) : ADDR_W'($urandom);
        bif.stride    = DIM_W'($urandom);
        for (int cyc = 1; cyc <= 8 + LAT; cyc++) begin
            if (cyc <= 8)
                chk($sformatf("addr_r%0d", cyc - 1), 128'({bif.read, bif.addr}), 128'({1'b1, ea[cyc-1]}));
            else
                chk("read_drain", 128'(bif.read), 128'(0));
            chk("busy", 128'(bif.busy), 128'(1));
            chk("done_early", 128'(bif.done), 128'(0));
            if (mode == 1) begin
                bif.start = (cyc == 5);
                if (cyc == 5) bif.base_addr = ADDR_W'(12'h500);
            end
            tick();
        end
        chk("done", 128'(bif.done), 128'(1));
        chk("busy_done", 128'(bif.busy), 128'(0));
        chk("read_done", 128'(bif.read), 128'(0));
        chk_tile("tile", ea, 1'b0);
        bif.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            chk("idle_done", 128'(bif.done), 128'(0));
            chk("idle_busy", 128'(bif.busy), 128'(0));
            chk("idle_read", 128'(bif.read), 128'(0));
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] zea [8];
        int mode;
        for (int r = 0; r < 8; r++) zea[r] = '0;
        reset = 1'b1; bif.start = 1'b0; bif.base_addr = '0; bif.stride = '0;
        repeat (3) tick();
        chk("rst_busy", 128'(bif.busy), 128'(0));
        chk("rst_done", 128'(bif.done), 128'(0));
        chk("rst_read", 128'(bif.read), 128'(0));
        chk("rst_addr", 128'(bif.addr), 128'(0));
        chk_tile("rst_tile", zea, 1'b1);
        reset = 1'b0;
        tick();

        fetch(ADDR_W'(12'h100), DIM_W'(4), 0);
        idle(2);
        fetch(ADDR_W'(12'h100), DIM_W'(4), 1);
        idle(3);
        fetch(ADDR_W'(12'h100), DIM_W'(4), 2);
        fetch(ADDR_W'(12'h200), DIM_W'(4), 0);
        idle(2);
        fetch(ADDR_W'((1 << ADDR_W) - 8), DIM_W'(2), 0);
        fetch(ADDR_W'(12'h123), DIM_W'(0), 0);
        idle(1);

        // Reset in cycle 6 of a fetch aborts it; late data must not land
        bif.start = 1'b1; bif.base_addr = ADDR_W'(12'h300); bif.stride = DIM_W'(3);
        tick();
        bif.start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 128'(bif.busy), 128'(0));
        chk("abort_read", 128'(bif.read), 128'(0));
        chk_tile("abort_tile", zea, 1'b1);
        idle(12);
        chk_tile("abort_late", zea, 1'b1);

        for (int k = 0; k < 25; k++) begin
            mode = $urandom_range(0, 2);
            fetch(ADDR_W'($urandom), ($urandom_range(0, 3) == 0) ? DIM_W'(0) : DIM_W'($urandom), mode);
            if (mode != 2) idle($urandom_range(0, 3));
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
